// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, constants and helpers for the display scan controller
// Contents:
//   scan_state_t   : ST_BLANK (all anodes off) / ST_SHOW (one digit driven)
//   NUM_DIG        : number of multiplexed digit positions
//   ANODE_OFF      : active-low anode pattern with every digit off
//   cnt_width()    : slot counter width for a given TICK_DIV
//   lz_suppressed(): leading-zero test for one digit position of a 16-bit value
package seg_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int         NUM_DIG   = 4;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    function automatic int cnt_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

    // A digit is a leading zero when it and every higher digit are zero.
    // Digit 0 always shows so a zero value still displays "0".
    function automatic logic lz_suppressed(input logic [15:0] val, input logic [1:0] idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (i >= int'(idx) && val[4*i +: 4] != 4'd0) begin
                r = 1'b0;
            end
        end
        if (idx == 2'd0) begin
            r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - digit slot counter with blank-end / slot-end strobes and digit index
// Ports:
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   o_blank_end  : high on the last blank cycle of a slot (counter == BLANK_CYC-1)
//   o_slot_end   : high on the last cycle of a slot (counter == TICK_DIV-1)
//   o_idx        : current digit index 0..3, advances when the slot ends
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_blank_end,
    output logic       o_slot_end,
    output logic [1:0] o_idx
);

    localparam int            CW         = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    // Strobes fire one cycle early so the registered outputs in the
    // controller change on the same edge the counter reaches the boundary.
    assign o_slot_end  = (r_cnt == SLOT_LAST);
    assign o_blank_end = (r_cnt == BLANK_LAST);
    assign o_idx       = r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (o_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit 7-segment scan scheduler with dead-time and frame-synchronous double buffer
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero suppression when defined)
// Ports:
//   i_mclk        : system clock
//   i_rs          : asynchronous active-low reset
//   i_value_in    : four nibbles to display, [3:0] is digit 0 (rightmost)
//   i_load        : one-cycle strobe capturing i_value_in / i_dp_in into the pending buffer
//   i_dp_in       : decimal point request per digit
//   i_digit_en    : per-digit enable, sampled live
//   o_anode       : active-low one-hot digit select
//   o_nibble      : code for the seg7 decoder
//   o_dp          : decimal point for the current digit, active-high
//   o_blank       : high while no digit is driven
//   o_frame_done  : one-cycle pulse as the index wraps 3->0
//   o_load_ack    : one-cycle pulse the cycle after each load
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        i_mclk,
    input  logic        i_rs,
    input  logic [15:0] i_value_in,
    input  logic        i_load,
    input  logic [3:0]  i_dp_in,
    input  logic [3:0]  i_digit_en,
    output logic [3:0]  o_anode,
    output logic [3:0]  o_nibble,
    output logic        o_dp,
    output logic        o_blank,
    output logic        o_frame_done,
    output logic        o_load_ack
);

    scan_state_t r_state;
    logic [15:0] r_active;
    logic [3:0]  r_active_dp;
    logic [15:0] r_pending;
    logic [3:0]  r_pending_dp;
    logic        r_pend_flag;

    logic        w_blank_end;
    logic        w_slot_end;
    logic [1:0]  w_idx;
    logic        w_boundary;
    logic        w_next_show;
    logic        w_lz;
    logic        w_dig_on;

    scan_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan_timer (
        .i_clk       (i_mclk),
        .i_rst_n     (i_rs),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end),
        .o_idx       (w_idx)
    );

    assign w_boundary  = w_slot_end && (w_idx == 2'd3);

    // State the FSM holds after this edge; outputs are computed for it so
    // they change together with the state.
    assign w_next_show = ((r_state == ST_SHOW)  && !w_slot_end) ||
                         ((r_state == ST_BLANK) &&  w_blank_end);

`ifdef SEG_SCAN_LZ_BLANK_EN
    // r_active only changes at the frame boundary, which is always a blank
    // cycle, so the suppression decision is stable across a SHOW period.
    assign w_lz = lz_suppressed(r_active, w_idx);
`else
    assign w_lz = 1'b0;
`endif

    assign w_dig_on = i_digit_en[w_idx] && !w_lz;

    always_ff @(posedge i_mclk or negedge i_rs) begin
        if (!i_rs) begin
            r_state      <= ST_BLANK;
            r_active     <= 16'd0;
            r_active_dp  <= 4'd0;
            r_pending    <= 16'd0;
            r_pending_dp <= 4'd0;
            r_pend_flag  <= 1'b0;
            o_anode      <= ANODE_OFF;
            o_nibble     <= 4'd0;
            o_dp         <= 1'b0;
            o_blank      <= 1'b1;
            o_frame_done <= 1'b0;
            o_load_ack   <= 1'b0;
        end else begin
            o_frame_done <= w_boundary;
            o_load_ack   <= i_load;

            if (w_boundary && r_pend_flag) begin
                r_active    <= r_pending;
                r_active_dp <= r_pending_dp;
                r_pend_flag <= 1'b0;
            end

            // A load on the boundary edge overrides the flag clear above,
            // so its value waits in pending for the following frame.
            if (i_load) begin
                r_pending    <= i_value_in;
                r_pending_dp <= i_dp_in;
                r_pend_flag  <= 1'b1;
            end

            case (r_state)
                ST_BLANK: if (w_blank_end) r_state <= ST_SHOW;
                ST_SHOW:  if (w_slot_end)  r_state <= ST_BLANK;
            endcase

            if (w_next_show) begin
                o_anode  <= w_dig_on ? ~(4'b0001 << w_idx) : ANODE_OFF;
                o_blank  <= !w_dig_on;
                o_nibble <= r_active[4*w_idx +: 4];
                o_dp     <= r_active_dp[w_idx];
            end else begin
                o_anode  <= ANODE_OFF;
                o_blank  <= 1'b1;
                o_nibble <= 4'd0;
                o_dp     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with TICK_DIV=8, BLANK_CYC=2
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rs = 1'b1;
    logic [15:0] value_in = 16'd0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'd0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  anode;
    logic [3:0]  nibble;
    logic        dp;
    logic        blank;
    logic        frame_done;
    logic        load_ack;

    int k = 0;
    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(
        .TICK_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .i_mclk       (mclk),
        .i_rs         (rs),
        .i_value_in   (value_in),
        .i_load       (load),
        .i_dp_in      (dp_in),
        .i_digit_en   (digit_en),
        .o_anode      (anode),
        .o_nibble     (nibble),
        .o_dp         (dp),
        .o_blank      (blank),
        .o_frame_done (frame_done),
        .o_load_ack   (load_ack)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic [15:0] an;   // expected anode per digit, digit d at [4*d +: 4]
    } vec_t;

    vec_t vt [7];
    int   rk [6];
    logic [3:0] ra [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got=%h expected=%h", name, k, act, exp);
        end
    endtask

    // One clock; k counts rising edges since the last reset release.
    task automatic tick();
        @(negedge mclk);
        k++;
        chk("frame_done", 16'(frame_done), 16'(k % 32 == 0));
    endtask

    task automatic goto_phase(input int p);
        tick();
        while (k % 32 != p) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("load_ack_hi", 16'(load_ack), 16'd1);
    endtask

    initial begin
        vt[0] = '{16'h1234, 4'b0000, 4'b1111, 16'h7BDE};
        vt[1] = '{16'hABCD, 4'b0101, 4'b1111, 16'h7BDE};
        vt[2] = '{16'h5678, 4'b0100, 4'b0101, 16'hFBFE};
        vt[3] = '{16'h0050, 4'b0000, 4'b1111, LZ ? 16'hFFDE : 16'h7BDE};
        vt[4] = '{16'h0000, 4'b0000, 4'b1111, LZ ? 16'hFFFE : 16'h7BDE};
        vt[5] = '{16'h0708, 4'b0001, 4'b1111, LZ ? 16'hFBDE : 16'h7BDE};
        vt[6] = '{16'h4321, 4'b1000, 4'b1111, 16'h7BDE};
        rk = '{1, 2, 7, 8, 9, 10};
        ra = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

        // Reset state
        #1 rs = 1'b0;
        repeat (3) @(negedge mclk);
        chk("rst_anode", 16'(anode), 16'hF);
        chk("rst_blank", 16'(blank), 16'd1);
        chk("rst_nibble", 16'(nibble), 16'd0);
        chk("rst_dp", 16'(dp), 16'd0);
        chk("rst_frame_done", 16'(frame_done), 16'd0);
        chk("rst_load_ack", 16'(load_ack), 16'd0);
        rs = 1'b1;
        k  = 0;

        // First slots after release: blank 2, show 6, blank 2, next digit
        for (int i = 0; i < 6; i++) begin
            while (k < rk[i]) tick();
            chk("startup_anode", 16'(anode), 16'(ra[i]));
        end

        // Table: load mid-frame, check every slot of the following frame
        for (int v = 0; v < 7; v++) begin
            goto_phase(0);
            digit_en = vt[v].en;
            goto_phase(5);
            do_load(vt[v].val, vt[v].dpv);
            tick();
            chk("load_ack_lo", 16'(load_ack), 16'd0);
            goto_phase(0);
            for (int d = 0; d < 4; d++) begin
                logic [3:0] ea;
                ea = vt[v].an[4*d +: 4];
                goto_phase(8*d + 1);
                chk("vec_dead_anode", 16'(anode), 16'hF);
                chk("vec_dead_blank", 16'(blank), 16'd1);
                goto_phase(8*d + 4);
                chk("vec_anode", 16'(anode), 16'(ea));
                chk("vec_blank", 16'(blank), 16'(ea == 4'hF));
                if (ea != 4'hF) begin
                    chk("vec_nibble", 16'(nibble), 16'(vt[v].val[4*d +: 4]));
                    chk("vec_dp", 16'(dp), 16'(vt[v].dpv[d]));
                end
            end
        end

        // Load on the boundary cycle with the flag clear: one frame late
        goto_phase(31);
        do_load(16'h9876, 4'b0000);
        goto_phase(4);
        chk("bnd_old_d0", 16'(nibble), 16'h1);
        goto_phase(28);
        chk("bnd_old_d3", 16'(nibble), 16'h4);
        goto_phase(4);
        chk("bnd_new_d0", 16'(nibble), 16'h6);
        goto_phase(28);
        chk("bnd_new_d3", 16'(nibble), 16'h9);

        // Two loads in one frame: current frame keeps old value, last load wins
        goto_phase(3);
        do_load(16'h1111, 4'b0000);
        goto_phase(10);
        do_load(16'h2222, 4'b0000);
        goto_phase(20);
        chk("multi_old_d2", 16'(nibble), 16'h8);
        goto_phase(4);
        chk("multi_last_d0", 16'(nibble), 16'h2);
        goto_phase(12);
        chk("multi_last_d1", 16'(nibble), 16'h2);

        // Asynchronous reset during digit 2 SHOW
        goto_phase(20);
        chk("pre_rst_anode", 16'(anode), 16'hB);
        rs = 1'b0;
        #1;
        chk("async_rst_anode", 16'(anode), 16'hF);
        chk("async_rst_blank", 16'(blank), 16'd1);
        chk("async_rst_nibble", 16'(nibble), 16'd0);
        repeat (2) @(negedge mclk);
        chk("hold_rst_anode", 16'(anode), 16'hF);
        rs = 1'b1;
        k  = 0;
        repeat (4) tick();
        chk("post_rst_d0_anode", 16'(anode), 16'hE);
        chk("post_rst_d0_nibble", 16'(nibble), 16'd0);
        goto_phase(12);
        chk("post_rst_d1_anode", 16'(anode), LZ ? 16'hF : 16'hD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
